// File: rtl/fp_align_ctrl.sv
// Operand-alignment controller for the single-precision adder: orders the pair by
// magnitude, drives the shared right-shifter with the exponent gap, presents the aligned pair.
module fp_align_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] big_m,
  output logic [23:0] small_m,
  output logic [7:0]  exp_out,
  output logic        sign_big,
  output logic        eff_sub,
  output logic        swapped,
  output logic        special,
  output logic [7:0]  sh_e,
  output logic [23:0] sh_m,
  input  logic [23:0] sh_o
);

  typedef enum logic [1:0] {IDLE, CMP, SHIFT, OUT} state_t;

  state_t      state_q;
  logic [31:0] a_q, b_q;
  logic        in_ready_q, out_valid_q;
  logic [23:0] big_m_q, small_m_q, sh_m_q;
  logic [7:0]  exp_q, sh_e_q;
  logic        sign_big_q, eff_sub_q, swapped_q, special_q;

  // Unpacked view of the latched pair; denormals use exponent 1 and no hidden bit.
  logic [7:0]  ea, eb, diff;
  logic [23:0] ma, mb;
  logic        pick_b;

  always_comb begin
    ea     = (a_q[30:23] == 8'd0) ? 8'd1 : a_q[30:23];
    eb     = (b_q[30:23] == 8'd0) ? 8'd1 : b_q[30:23];
    ma     = {|a_q[30:23], a_q[22:0]};
    mb     = {|b_q[30:23], b_q[22:0]};
    pick_b = (eb > ea) || ((eb == ea) && (mb > ma));
    diff   = pick_b ? (eb - ea) : (ea - eb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      big_m_q     <= '0;
      small_m_q   <= '0;
      exp_q       <= '0;
      sign_big_q  <= 1'b0;
      eff_sub_q   <= 1'b0;
      swapped_q   <= 1'b0;
      special_q   <= 1'b0;
      sh_e_q      <= '0;
      sh_m_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q        <= a;
          b_q        <= b;
          in_ready_q <= 1'b0;
          state_q    <= CMP;
        end
        CMP: begin
          big_m_q    <= pick_b ? mb : ma;
          exp_q      <= pick_b ? eb : ea;
          sign_big_q <= pick_b ? b_q[31] : a_q[31];
          eff_sub_q  <= a_q[31] ^ b_q[31];
          swapped_q  <= pick_b;
          special_q  <= (&a_q[30:23]) | (&b_q[30:23]);
          // Shifter operands are registered here so they are live for exactly the SHIFT cycle.
          sh_e_q     <= diff;
          sh_m_q     <= pick_b ? ma : mb;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          small_m_q   <= sh_o;
          sh_e_q      <= '0;
          sh_m_q      <= '0;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign big_m     = big_m_q;
  assign small_m   = small_m_q;
  assign exp_out   = exp_q;
  assign sign_big  = sign_big_q;
  assign eff_sub   = eff_sub_q;
  assign swapped   = swapped_q;
  assign special   = special_q;
  assign sh_e      = sh_e_q;
  assign sh_m      = sh_m_q;

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Bench for fp_align_ctrl: directed spec vectors, randomized pairs against a magnitude
// model, backpressure and mid-operation reset.
module tb_fp_align_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, sign_big, eff_sub, swapped, special;
  logic [23:0] big_m, small_m, sh_m, sh_o;
  logic [7:0]  exp_out, sh_e;

  int total = 0, bad = 0;

  fp_align_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .big_m(big_m), .small_m(small_m),
    .exp_out(exp_out), .sign_big(sign_big), .eff_sub(eff_sub), .swapped(swapped),
    .special(special), .sh_e(sh_e), .sh_m(sh_m), .sh_o(sh_o)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared combinational shifter.
  assign sh_o = (sh_e >= 8'd24) ? 24'd0 : (sh_m >> sh_e);

  typedef struct packed {
    logic [23:0] big_m;
    logic [23:0] small_m;
    logic [7:0]  exp_out;
    logic        sign_big;
    logic        eff_sub;
    logic        swapped;
    logic        special;
  } res_t;

  typedef struct packed {
    res_t        r;
    logic [7:0]  diff;
    logic [23:0] pre;
  } ref_t;

  function automatic ref_t model(input logic [31:0] av, input logic [31:0] bv);
    longint ea, eb, ma, mb, bm, sm, be, d;
    logic   bsel;
    ref_t   x;
    ea = (av[30:23] == 8'd0) ? 1 : longint'(av[30:23]);
    eb = (bv[30:23] == 8'd0) ? 1 : longint'(bv[30:23]);
    ma = longint'(av[22:0]) + ((av[30:23] != 8'd0) ? (longint'(1) << 23) : 0);
    mb = longint'(bv[22:0]) + ((bv[30:23] != 8'd0) ? (longint'(1) << 23) : 0);
    bsel = (eb * (longint'(1) << 24) + mb) > (ea * (longint'(1) << 24) + ma);
    if (bsel) begin be = eb; bm = mb; sm = ma; d = eb - ea; end
    else      begin be = ea; bm = ma; sm = mb; d = ea - eb; end
    x.r.big_m    = 24'(bm);
    x.r.small_m  = (d >= 24) ? 24'd0 : 24'(sm / (longint'(1) << d));
    x.r.exp_out  = 8'(be);
    x.r.sign_big = bsel ? bv[31] : av[31];
    x.r.eff_sub  = av[31] ^ bv[31];
    x.r.swapped  = bsel;
    x.r.special  = (av[30:23] == 8'hFF) || (bv[30:23] == 8'hFF);
    x.diff       = 8'(d);
    x.pre        = 24'(sm);
    return x;
  endfunction

  function automatic res_t dut_res();
    res_t o;
    o.big_m = big_m; o.small_m = small_m; o.exp_out = exp_out; o.sign_big = sign_big;
    o.eff_sub = eff_sub; o.swapped = swapped; o.special = special;
    return o;
  endfunction

  // Runs one pair from a negedge in IDLE; hold = cycles of out_ready=0 with in_valid=1.
  task automatic run_check(input logic [31:0] av, input logic [31:0] bv, input int hold,
                           input string nm);
    ref_t e;
    int   w;
    e = model(av, bv);
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s accept: in_ready=%b want 1", nm, in_ready); end
    in_valid = 1'b1; a = av; b = bv;
    @(posedge clk); #1 in_valid = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, sh_e, sh_m} !== 34'd0) begin
      bad++; $display("FAIL %s cmp: rdy=%b vld=%b sh_e=%h sh_m=%h want all 0", nm, in_ready, out_valid, sh_e, sh_m);
    end
    @(negedge clk);
    total++;
    if (sh_e !== e.diff || sh_m !== e.pre || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL %s shift: sh_e=%h sh_m=%h vld=%b want %h %h 0", nm, sh_e, sh_m, out_valid, e.diff, e.pre);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL %s latency: out_valid=%b in_ready=%b want 1 0", nm, out_valid, in_ready);
    end
    total++;
    if (dut_res() !== e.r) begin
      bad++; $display("FAIL %s data: got %h want %h", nm, dut_res(), e.r);
    end
    if (hold > 0) begin
      in_valid = 1'b1; a = 32'h7F800000; b = $urandom;
      for (int i = 0; i < hold; i++) begin
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut_res() !== e.r || sh_e !== 8'd0) begin
          bad++; $display("FAIL %s hold%0d: vld=%b rdy=%b data=%h want 1 0 %h", nm, i, out_valid, in_ready, dut_res(), e.r);
        end
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_res() !== e.r) begin
      bad++; $display("FAIL %s handoff: vld=%b rdy=%b data=%h want 0 1 %h", nm, out_valid, in_ready, dut_res(), e.r);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (in_ready !== 1'b1 || {out_valid, dut_res(), sh_e, sh_m} !== '0) begin
      bad++; $display("FAIL reset: rdy=%b vld=%b data=%h sh_e=%h sh_m=%h want 1 0 0 0 0", in_ready, out_valid, dut_res(), sh_e, sh_m);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] da[8] = '{32'h40000000, 32'h3F800000, 32'h4B000000, 32'h4B800000,
                         32'h7F000000, 32'h00000001, 32'h3F800000, 32'h7F800000};
  logic [31:0] db[8] = '{32'h3F800000, 32'hC0000000, 32'h3F800000, 32'h3F800000,
                         32'h3F800000, 32'h00000002, 32'h3F800000, 32'h3F800000};
  logic [59:0] dr[8] = '{{24'h800000, 24'h400000, 8'h80, 4'b0000},
                         {24'h800000, 24'h400000, 8'h80, 4'b1110},
                         {24'h800000, 24'h000001, 8'h96, 4'b0000},
                         {24'h800000, 24'h000000, 8'h97, 4'b0000},
                         {24'h800000, 24'h000000, 8'hFE, 4'b0000},
                         {24'h000002, 24'h000001, 8'h01, 4'b0010},
                         {24'h800000, 24'h800000, 8'h7F, 4'b0000},
                         {24'h800000, 24'h000000, 8'hFF, 4'b0001}};

  task automatic test_directed();
    for (int i = 0; i < 8; i++) begin
      run_check(da[i], db[i], 0, $sformatf("dir%0d", i));
      total++;
      if (dut_res() !== res_t'(dr[i])) begin
        bad++; $display("FAIL dir%0d const: got %h want %h", i, dut_res(), dr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] av, bv;
    int          ea, eb;
    for (int i = 0; i < 60; i++) begin
      ea = $urandom_range(0, 255);
      case ($urandom_range(0, 3))
        0:       eb = ea;
        1:       eb = ea + $urandom_range(0, 30) - 15;
        default: eb = $urandom_range(0, 255);
      endcase
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      av = {1'($urandom), 8'(ea), 23'($urandom)};
      bv = {1'($urandom), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) bv[22:0] = av[22:0];
      run_check(av, bv, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_backpressure();
    run_check(32'h40400000, 32'hBF000000, 5, "bp");
    run_check(32'h3F800000, 32'h40000000, 0, "bp_next");
  endtask

  task automatic test_reset_mid();
    int seen;
    in_valid = 1'b1; a = 32'h40000000; b = 32'h3F800000;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || {out_valid, dut_res(), sh_e, sh_m} !== '0) begin
      bad++; $display("FAIL rst_mid: rdy=%b vld=%b data=%h sh_e=%h want 1 0 0 0", in_ready, out_valid, dut_res(), sh_e);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rst_stale: out_valid high %0d cycles want 0", seen); end
    run_check(32'h7F800000, 32'h3F800000, 0, "rst_after");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
